// File: rtl/rf_pkg.sv
// Shared types, constants and helpers for the multiport register file.
package rf_pkg;

  localparam int RF_ADDR_W  = 5;
  localparam int RV32E_REGS = 16;
  localparam int RV32I_REGS = 32;

  typedef enum logic {RF_CLEAR, RF_RUN} rf_state_e;

  // An address is legal when it names an implemented architectural register.
  function automatic logic addr_legal(input logic [RF_ADDR_W-1:0] addr, input int num_regs);
    return int'(addr) < num_regs;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: legality check, optional write bypass, data/valid flops.
// Build option: define RF_WR_BYPASS_EN for write-first reads of the address being written.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = RV32E_REGS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acc_en,
  input  logic                 rd_req,
  input  logic [RF_ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]      mem_rdata,
  input  logic                 wr_fire,
  input  logic [RF_ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]      wr_data,
  output logic [XLEN-1:0]      rd_data,
  output logic                 rd_vld,
  output logic                 rd_fault
);

`ifdef RF_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            rd_fire;
  logic            rd_legal;
  logic            byp_hit;
  logic [XLEN-1:0] data_q, data_d;
  logic            vld_q, vld_d;

  // Select next read data: zero for x0/illegal, bypassed write data, or stored value.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
    rd_fire  = acc_en & rd_req;
    rd_legal = addr_legal(rd_addr, NUM_REGS);
    rd_fault = rd_fire & ~rd_legal;
    // wr_fire already excludes x0 and out-of-range writes.
    byp_hit  = BYPASS & wr_fire & (wr_addr == rd_addr);
    vld_d    = rd_fire;
    data_d   = data_q;
    if (rd_fire) begin
      if (!rd_legal || rd_addr == '0) data_d = '0;
      else if (byp_hit)               data_d = wr_data;
      else                            data_d = mem_rdata;
    end
  end

  // Registered read data and single-cycle valid.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign rd_data = data_q;
  assign rd_vld  = vld_q;

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file: N registered read ports, one write port, x0 hardwired
// to zero, post-reset clear sweep, out-of-range address fault reporting.
// Build option: RF_WR_BYPASS_EN selects write-first same-cycle read behaviour.
module regfile_multiport
  import rf_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = RV32E_REGS,
  parameter int NUM_RD   = 2,
  parameter int ADDR_W   = RF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rf_en,
  input  logic [NUM_RD-1:0]        rd_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_vld,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  output logic                     ready,
  output logic                     addr_fault,
  output logic [ADDR_W-1:0]        fault_addr
);

  localparam int              IDX_W    = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  // NOTE: the storage array has no reset; the clear sweep zeroes it, keeping it mappable to RAM/latch arrays.
  logic [XLEN-1:0]   mem_q [NUM_REGS];

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              ready_q, ready_d;
  logic              addr_fault_q, addr_fault_d;
  logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;

  logic              acc_en;
  logic              wr_legal;
  logic              wr_fire;
  logic              wr_fault;
  logic [NUM_RD-1:0] rd_fault;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [XLEN-1:0]   mem_wdata;

  // Accesses are accepted only once the sweep is done and the block is enabled.
  always_comb begin
    acc_en   = (state_q == RF_RUN) & rf_en;
    wr_legal = addr_legal(wr_addr, NUM_REGS);
    wr_fire  = acc_en & wr_en & wr_legal & (wr_addr != '0);
    wr_fault = acc_en & wr_en & ~wr_legal;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr_i;
    assign addr_i = rd_addr[i*ADDR_W +: ADDR_W];

    rf_read_port #(
      .XLEN     (XLEN),
      .NUM_REGS (NUM_REGS)
    ) u_port (
      .clk       (clk),
      .rst       (rst),
      .acc_en    (acc_en),
      .rd_req    (rd_req[i]),
      .rd_addr   (addr_i),
      .mem_rdata (mem_q[addr_i[IDX_W-1:0]]),
      .wr_fire   (wr_fire),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_data   (rd_data[i*XLEN +: XLEN]),
      .rd_vld    (rd_vld[i]),
      .rd_fault  (rd_fault[i])
    );
  end

  // Clear sweep sequencing and selection of the single storage write per cycle.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    mem_we    = 1'b0;
    mem_waddr = clr_idx_q[IDX_W-1:0];
    mem_wdata = '0;
    case (state_q)
      RF_CLEAR: begin
        mem_we = 1'b1;
        if (clr_idx_q == LAST_IDX) state_d   = RF_RUN;
        else                       clr_idx_d = clr_idx_q + ADDR_W'(1);
      end
      RF_RUN: begin
        if (wr_fire) begin
          mem_we    = 1'b1;
          mem_waddr = wr_addr[IDX_W-1:0];
          mem_wdata = wr_data;
        end
      end
      default: state_d = RF_CLEAR;
    endcase
    ready_d = (state_d == RF_RUN);
  end

  // Fault pulse and address capture; the write port beats read ports, lower port beats higher.
  always_comb begin
    addr_fault_d = wr_fault | (|rd_fault);
    fault_addr_d = fault_addr_q;
    if (wr_fault) begin
      fault_addr_d = wr_addr;
    end else begin
      for (int i = NUM_RD - 1; i >= 0; i--) begin
        if (rd_fault[i]) fault_addr_d = rd_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Control state, ready and fault registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RF_CLEAR;
      clr_idx_q    <= ADDR_W'(1);
      ready_q      <= 1'b0;
      addr_fault_q <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      ready_q      <= ready_d;
      addr_fault_q <= addr_fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // Register storage write (clear sweep or accepted write).
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign ready      = ready_q;
  assign addr_fault = addr_fault_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport (NUM_REGS=16, two read ports).
module tb_regfile_multiport;

  localparam int XLEN  = 32;
  localparam int NREGS = 16;
  localparam int NRD   = 2;
  localparam int AW    = 5;

`ifdef RF_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  rf_en;
  logic [NRD-1:0]        rd_req;
  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD*XLEN-1:0]   rd_data;
  logic [NRD-1:0]        rd_vld;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  ready;
  logic                  addr_fault;
  logic [AW-1:0]         fault_addr;

  always #5 clk = ~clk;

  regfile_multiport #(
    .XLEN     (XLEN),
    .NUM_REGS (NREGS),
    .NUM_RD   (NRD),
    .ADDR_W   (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rf_en      (rf_en),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_vld     (rd_vld),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .ready      (ready),
    .addr_fault (addr_fault),
    .fault_addr (fault_addr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [XLEN-1:0]     m_regs [32];
  int                  m_clr_left = 0;
  bit                  m_valid = 1'b0;
  logic [NRD*XLEN-1:0] e_rd_data;
  logic [NRD-1:0]      e_rd_vld;
  logic                e_ready;
  logic                e_fault;
  logic [AW-1:0]       e_fault_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic [AW-1:0]   a;
    logic [XLEN-1:0] v;
    bit              rd_flt;
    logic [AW-1:0]   rd_fa;
    bit              wr_flt;
    rd_flt = 1'b0;
    rd_fa  = '0;
    if (rst) begin
      for (int r = 0; r < 32; r++) m_regs[r] = '0;
      m_clr_left   = NREGS - 1;
      m_valid      = 1'b1;
      e_rd_data    = '0;
      e_rd_vld     = '0;
      e_ready      = 1'b0;
      e_fault      = 1'b0;
      e_fault_addr = '0;
    end else if (!m_valid) begin
      // nothing known before the first reset
    end else if (m_clr_left > 0) begin
      m_clr_left--;
      e_ready  = (m_clr_left == 0);
      e_rd_vld = '0;
      e_fault  = 1'b0;
    end else if (!rf_en) begin
      e_rd_vld = '0;
      e_fault  = 1'b0;
    end else begin
      for (int p = 0; p < NRD; p++) begin
        e_rd_vld[p] = rd_req[p];
        if (rd_req[p]) begin
          a = rd_addr[p*AW +: AW];
          if (int'(a) >= NREGS) begin
            v = '0;
            if (!rd_flt) begin
              rd_flt = 1'b1;
              rd_fa  = a;
            end
          end else if (a == 0) begin
            v = '0;
          end else if (BYP && wr_en && wr_addr == a) begin
            v = wr_data;
          end else begin
            v = m_regs[a];
          end
          e_rd_data[p*XLEN +: XLEN] = v;
        end
      end
      wr_flt = wr_en && (int'(wr_addr) >= NREGS);
      if (wr_en && !wr_flt && wr_addr != 0) m_regs[wr_addr] = wr_data;
      e_fault = wr_flt || rd_flt;
      if (wr_flt)      e_fault_addr = wr_addr;
      else if (rd_flt) e_fault_addr = rd_fa;
    end
  endtask

  // One clock: update the model at the edge, compare every output 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (m_valid) begin
      check("rd_data", 64'(rd_data), 64'(e_rd_data));
      check("rd_vld", 64'(rd_vld), 64'(e_rd_vld));
      check("ready", 64'(ready), 64'(e_ready));
      check("addr_fault", 64'(addr_fault), 64'(e_fault));
      check("fault_addr", 64'(fault_addr), 64'(e_fault_addr));
    end
  endtask

  task automatic idle();
    rf_en   = 1'b1;
    rd_req  = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [NRD-1:0] req, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_req  = req;
    rd_addr = {a1, a0};
    step();
    rd_req = '0;
  endtask

  // Reset pulse, then wait out the sweep while pinning the ready timing.
  task automatic reset_and_sweep(input string tag);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check({tag, "_ready_at_rst"}, 64'(ready), 64'd0);
    for (int i = 1; i <= 14; i++) begin
      step();
      check({tag, "_ready_low"}, 64'(ready), 64'd0);
    end
    step();
    check({tag, "_ready_high"}, 64'(ready), 64'd1);
  endtask

  initial begin
    logic [AW-1:0] a0, a1;
    rst     = 1'b1;
    rd_addr = '0;
    idle();

    // 1: reset, sweep timing, all registers read zero
    reset_and_sweep("t1");
    for (int a = 1; a < NREGS; a++) begin
      do_read(2'b11, AW'(a), AW'(NREGS - a));
      check("t1_read_zero", 64'(rd_data), 64'd0);
    end

    // 2: write x5 then read it on both ports
    do_write(5'd5, 32'hDEADBEEF);
    do_read(2'b11, 5'd5, 5'd5);
    check("t2_data", 64'(rd_data), {32'hDEADBEEF, 32'hDEADBEEF});
    check("t2_vld", 64'(rd_vld), 64'd3);

    // 3: writes to x0 are discarded without fault
    do_write(5'd0, 32'h1234);
    check("t3_wr_nofault", 64'(addr_fault), 64'd0);
    do_read(2'b01, 5'd0, 5'd0);
    check("t3_data", 64'(rd_data[31:0]), 64'd0);
    check("t3_nofault", 64'(addr_fault), 64'd0);

    // 4: out-of-range write and read in one cycle
    do_write(5'd4, 32'h44444444);
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'hBAD0BAD0;
    do_read(2'b10, 5'd0, 5'd17);
    wr_en = 1'b0;
    check("t4_fault", 64'(addr_fault), 64'd1);
    check("t4_fault_addr", 64'(fault_addr), 64'd20);
    check("t4_p1_data", 64'(rd_data[63:32]), 64'd0);
    check("t4_vld", 64'(rd_vld), 64'd2);
    step();
    check("t4_pulse_end", 64'(addr_fault), 64'd0);
    check("t4_fault_addr_hold", 64'(fault_addr), 64'd20);
    do_read(2'b01, 5'd4, 5'd0);
    check("t4_x4_intact", 64'(rd_data[31:0]), 64'h44444444);

    // 5: same-cycle write and read of x3
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
    do_read(2'b01, 5'd3, 5'd0);
    wr_en = 1'b0;
    check("t5_same_cycle", 64'(rd_data[31:0]), BYP ? 64'hA5A5A5A5 : 64'd0);
    do_read(2'b01, 5'd3, 5'd0);
    check("t5_after", 64'(rd_data[31:0]), 64'hA5A5A5A5);

    // 6: reset mid-sweep (clr_idx=7) restarts the sweep
    do_write(5'd9, 32'h99999999);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();
    reset_and_sweep("t6");
    do_read(2'b11, 5'd9, 5'd5);
    check("t6_cleared", 64'(rd_data), 64'd0);

    // rf_en low: requests ignored, no write
    rf_en = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77777777;
    do_read(2'b11, 5'd25, 5'd7);
    wr_en = 1'b0;
    rf_en = 1'b1;
    check("en0_vld", 64'(rd_vld), 64'd0);
    check("en0_fault", 64'(addr_fault), 64'd0);
    do_read(2'b01, 5'd7, 5'd0);
    check("en0_nowrite", 64'(rd_data[31:0]), 64'd0);

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(0, 499) == 0);
      rf_en  = ($urandom_range(0, 9) != 0);
      rd_req = NRD'($urandom);
      wr_en  = $urandom_range(0, 1) == 1;
      wr_addr = ($urandom_range(0, 9) < 8) ? AW'($urandom_range(0, NREGS - 1)) : AW'($urandom_range(0, 31));
      wr_data = $urandom;
      a0 = ($urandom_range(0, 9) < 8) ? AW'($urandom_range(0, NREGS - 1)) : AW'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 9) < 8) ? AW'($urandom_range(0, NREGS - 1)) : AW'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) a0 = wr_addr;
      if ($urandom_range(0, 7) == 0) a1 = a0;
      rd_addr = {a1, a0};
      step();
    end

    rst = 1'b0;
    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
